// File: rtl/gray_sobel_frame_ctrl_if.sv
// Pixel path between the SPI link, the frame sequencer and the gray/Sobel core.
// master = sequencer side, slave = surrounding pixel sources/sinks.
interface gray_sobel_frame_ctrl_if #(
  parameter int PIXEL_BITS = 24
);
  logic                  in_px_rdy_i;
  logic [PIXEL_BITS-1:0] in_px_i;
  logic                  core_px_rdy_o;
  logic [PIXEL_BITS-1:0] core_px_o;
  logic                  core_px_rdy_i;

  modport master (
    input  in_px_rdy_i,
    input  in_px_i,
    input  core_px_rdy_i,
    output core_px_rdy_o,
    output core_px_o
  );

  modport slave (
    output in_px_rdy_i,
    output in_px_i,
    output core_px_rdy_i,
    input  core_px_rdy_o,
    input  core_px_o
  );
endinterface

// File: rtl/gray_sobel_frame_ctrl.sv
// Frame sequencer: latches mode, pulses Sobel start, forwards one frame,
// counts core outputs and flags drain timeout / stray pixels.
module gray_sobel_frame_ctrl #(
  parameter int PIXEL_BITS    = 24,
  parameter int IMG_W         = 32,
  parameter int IMG_H         = 32,
  parameter int OUT_TOTAL     = IMG_W * IMG_H,
  parameter int DRAIN_TIMEOUT = 1024,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic          clk_i,
  input  logic          nreset_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [1:0]    mode_i,
  gray_sobel_frame_ctrl_if.master px,
  output logic [1:0]    core_select_o,
  output logic          core_start_sobel_o,
  output logic          busy_o,
  output logic          frame_done_o,
  output logic [1:0]    err_o,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int NW   = $clog2(NPIX + 1);
  localparam int OW   = $clog2(OUT_TOTAL + 1);
  localparam int IW   = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [NW-1:0] IN_LAST  = NW'(NPIX - 1);
  localparam logic [OW-1:0] OUT_MAX  = OW'(OUT_TOTAL);
  localparam logic [IW-1:0] IDLE_LAST = IW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state, w_state;
  logic [1:0]            r_sel, w_sel;
  logic                  r_start, w_start;
  logic                  r_px_rdy, w_px_rdy;
  logic [PIXEL_BITS-1:0] r_px, w_px;
  logic                  r_done, w_done;
  logic [1:0]            r_err, w_err;
  logic [CW-1:0]         r_col, w_col;
  logic [RW-1:0]         r_row, w_row;
  logic [NW-1:0]         r_in_cnt, w_in_cnt;
  logic [OW-1:0]         r_out_cnt, w_out_cnt;
  logic [IW-1:0]         r_idle, w_idle;
  logic                  w_out_inc;

  // Outputs past the expected total are ignored, not flagged.
  assign w_out_inc = px.core_px_rdy_i && (r_out_cnt != OUT_MAX);

  always_comb begin
    w_state   = r_state;
    w_sel     = r_sel;
    w_start   = 1'b0;
    w_px_rdy  = 1'b0;
    w_px      = r_px;
    w_done    = 1'b0;
    w_err     = r_err;
    w_col     = r_col;
    w_row     = r_row;
    w_in_cnt  = r_in_cnt;
    w_out_cnt = r_out_cnt;
    w_idle    = r_idle;
    if (abort_i) begin
      w_state   = S_IDLE;
      w_col     = '0;
      w_row     = '0;
      w_in_cnt  = '0;
      w_out_cnt = '0;
      w_idle    = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            w_state   = S_STREAM;
            w_start   = 1'b1;
            w_sel     = mode_i;
            w_err     = 2'b00;
            w_col     = '0;
            w_row     = '0;
            w_in_cnt  = '0;
            w_out_cnt = '0;
            w_idle    = '0;
          end
          if (px.in_px_rdy_i) w_err[0] = 1'b1;
        end
        S_STREAM: begin
          if (w_out_inc) w_out_cnt = r_out_cnt + OW'(1);
          if (px.in_px_rdy_i) begin
            w_px_rdy = 1'b1;
            w_px     = px.in_px_i;
            w_in_cnt = r_in_cnt + NW'(1);
            if (r_in_cnt == IN_LAST) begin
              w_state = S_DRAIN;
              w_idle  = '0;
              w_col   = '0;
              w_row   = '0;
            end else if (r_col == COL_LAST) begin
              w_col = '0;
              w_row = r_row + RW'(1);
            end else begin
              w_col = r_col + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (px.in_px_rdy_i) w_err[0] = 1'b1;
          if (w_out_inc) w_out_cnt = r_out_cnt + OW'(1);
          if (r_out_cnt == OUT_MAX) begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end else if (px.core_px_rdy_i) begin
            w_idle = '0;
          end else if (r_idle == IDLE_LAST) begin
            w_state  = S_DONE;
            w_done   = 1'b1;
            w_err[1] = 1'b1;
          end else begin
            w_idle = r_idle + IW'(1);
          end
        end
        S_DONE: begin
          w_state = S_IDLE;
          if (px.in_px_rdy_i) w_err[0] = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state   <= S_IDLE;
      r_sel     <= 2'b00;
      r_start   <= 1'b0;
      r_px_rdy  <= 1'b0;
      r_px      <= '0;
      r_done    <= 1'b0;
      r_err     <= 2'b00;
      r_col     <= '0;
      r_row     <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_idle    <= '0;
    end else begin
      r_state   <= w_state;
      r_sel     <= w_sel;
      r_start   <= w_start;
      r_px_rdy  <= w_px_rdy;
      r_px      <= w_px;
      r_done    <= w_done;
      r_err     <= w_err;
      r_col     <= w_col;
      r_row     <= w_row;
      r_in_cnt  <= w_in_cnt;
      r_out_cnt <= w_out_cnt;
      r_idle    <= w_idle;
    end
  end

  assign core_select_o      = r_sel;
  assign core_start_sobel_o = r_start;
  assign px.core_px_rdy_o   = r_px_rdy;
  assign px.core_px_o       = r_px;
  assign busy_o = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign frame_done_o       = r_done;
  assign err_o              = r_err;
  assign col_o              = r_col;
  assign row_o              = r_row;

endmodule
